// File: rtl/pif_ram_arbiter.sv
// 512x32 PIF RAM shared by the N64 serial word port and the PIF CPU byte port.
// N64 side is ROM-protected below RAM_BASE_WORD; writes to CMD_WORD raise cmd_pending.
module pif_ram_arbiter #(
    parameter logic [8:0] RAM_BASE_WORD = 9'h1F0,
    parameter logic [8:0] CMD_WORD      = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  n64_address,
    input  logic        n64_wren,
    input  logic [31:0] n64_data_in,
    output logic [31:0] n64_data_out,
    input  logic [3:0]  cpu_address,
    input  logic        cpu_wren,
    input  logic        cpu_oe,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_valid,
    output logic        cmd_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [0:511];

    logic [10:0] ptr_q, ptr_d;
    logic        dir_q, dir_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic [31:0] word_q, word_d;
    logic        hit_q, hit_d;
    logic        cmd_pending_q, cmd_pending_d;
    logic        irq_en_q, irq_en_d;
    logic        rom_unlock_q, rom_unlock_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic [7:0]  cpu_data_out_q, cpu_data_out_d;
    logic        cmd_irq_q, cmd_irq_d;
    logic [31:0] n64_data_out_q, n64_data_out_d;

    logic        n64_acc;
    logic        n64_hit;
    logic        busy;
    logic        strobe;
    logic        cpu_we;
    logic        clr_pending;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] cpu_word;
    logic [31:0] merged;
    logic [7:0]  sel_byte;

    assign n64_acc  = n64_wren && ((n64_address >= RAM_BASE_WORD) || rom_unlock_q);
    assign n64_hit  = n64_acc && (n64_address == ptr_q[10:2]);
    assign busy     = (state_q != S_IDLE);
    assign strobe   = cpu_wren | cpu_oe;
    assign cpu_word = mem[ptr_q[10:2]];

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        merged   = word_q;
        sel_byte = cpu_word[31:24];
        case (ptr_q[1:0])
            2'd0: begin
                merged[31:24] = wbyte_q;
                sel_byte      = cpu_word[31:24];
            end
            2'd1: begin
                merged[23:16] = wbyte_q;
                sel_byte      = cpu_word[23:16];
            end
            2'd2: begin
                merged[15:8] = wbyte_q;
                sel_byte     = cpu_word[15:8];
            end
            default: begin
                merged[7:0] = wbyte_q;
                sel_byte    = cpu_word[7:0];
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        dir_d          = dir_q;
        wbyte_d        = wbyte_q;
        word_d         = word_q;
        hit_d          = hit_q;
        irq_en_d       = irq_en_q;
        rom_unlock_d   = rom_unlock_q;
        cpu_valid_d    = 1'b0;
        cpu_data_out_d = 8'h00;
        cpu_we         = 1'b0;
        clr_pending    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe && cpu_address == 4'd2) begin
                    dir_d   = cpu_wren;
                    wbyte_d = cpu_data_in;
                    state_d = S_RD;
                end else if (strobe) begin
                    cpu_valid_d = 1'b1;
                    if (cpu_wren) begin
                        case (cpu_address)
                            4'd0: ptr_d[7:0]  = cpu_data_in;
                            4'd1: ptr_d[10:8] = cpu_data_in[2:0];
                            4'd3: begin
                                clr_pending = cpu_data_in[0];
                                if (cpu_data_in[2]) rom_unlock_d = 1'b1;
                            end
                            4'd4: irq_en_d = cpu_data_in[0];
                            default: ;
                        endcase
                    end else begin
                        case (cpu_address)
                            4'd0: cpu_data_out_d = ptr_q[7:0];
                            4'd1: cpu_data_out_d = {5'b0, ptr_q[10:8]};
                            4'd3: cpu_data_out_d = {5'b0, rom_unlock_q,
                                                    busy, cmd_pending_q};
                            4'd4: cpu_data_out_d = {7'b0, irq_en_q};
                            default: cpu_data_out_d = 8'h00;
                        endcase
                    end
                end
            end
            S_RD: begin
                word_d = cpu_word;
                hit_d  = n64_hit;
                if (dir_q) begin
                    state_d = S_WR;
                end else begin
                    cpu_valid_d    = 1'b1;
                    cpu_data_out_d = sel_byte;
                    state_d        = S_DONE;
                end
            end
            S_WR: begin
                hit_d = hit_q | n64_hit;
                // N64 owns the write port; a same-word N64 write forces a re-read.
                if (n64_wren) begin
                    state_d = S_WR;
                end else if (hit_q) begin
                    state_d = S_RD;
                end else begin
                    cpu_we      = 1'b1;
                    cpu_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: begin
                ptr_d   = ptr_q + 11'd1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_we    = n64_acc | (cpu_we & ~reset);
        mem_addr  = n64_acc ? n64_address : ptr_q[10:2];
        mem_wdata = n64_acc ? n64_data_in : merged;

        if (n64_acc && n64_address == CMD_WORD) begin
            cmd_pending_d = 1'b1;
        end else if (clr_pending) begin
            cmd_pending_d = 1'b0;
        end else begin
            cmd_pending_d = cmd_pending_q;
        end

        cmd_irq_d = cmd_pending_q & irq_en_q;

        if (mem_we && mem_addr == n64_address) begin
            n64_data_out_d = mem_wdata;
        end else begin
            n64_data_out_d = mem[n64_address];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= 11'd0;
            dir_q          <= 1'b0;
            wbyte_q        <= 8'h00;
            word_q         <= 32'h0;
            hit_q          <= 1'b0;
            cmd_pending_q  <= 1'b0;
            irq_en_q       <= 1'b0;
            rom_unlock_q   <= 1'b0;
            cpu_valid_q    <= 1'b0;
            cpu_data_out_q <= 8'h00;
            cmd_irq_q      <= 1'b0;
            n64_data_out_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            dir_q          <= dir_d;
            wbyte_q        <= wbyte_d;
            word_q         <= word_d;
            hit_q          <= hit_d;
            cmd_pending_q  <= cmd_pending_d;
            irq_en_q       <= irq_en_d;
            rom_unlock_q   <= rom_unlock_d;
            cpu_valid_q    <= cpu_valid_d;
            cpu_data_out_q <= cpu_data_out_d;
            cmd_irq_q      <= cmd_irq_d;
            n64_data_out_q <= n64_data_out_d;
        end
    end

    assign n64_data_out = n64_data_out_q;
    assign cpu_data_out = cpu_data_out_q;
    assign cpu_valid    = cpu_valid_q;
    assign cmd_irq      = cmd_irq_q;

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Testbench for pif_ram_arbiter: register table, scoreboarded CPU
// completions, and hand-written RMW / collision / reset sequences.
module tb_pif_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [8:0]  n64_address;
    logic        n64_wren;
    logic [31:0] n64_data_in;
    logic [31:0] n64_data_out;
    logic [3:0]  cpu_address;
    logic        cpu_wren;
    logic        cpu_oe;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_valid;
    logic        cmd_irq;

    pif_ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .n64_address  (n64_address),
        .n64_wren     (n64_wren),
        .n64_data_in  (n64_data_in),
        .n64_data_out (n64_data_out),
        .cpu_address  (cpu_address),
        .cpu_wren     (cpu_wren),
        .cpu_oe       (cpu_oe),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_valid    (cpu_valid),
        .cmd_irq      (cmd_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        bit         chk;
        logic [7:0] d;
        string      nm;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit         wr;
        bit         oe;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        string      nm;
    } vec_t;
    vec_t vt [14];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Every completion pops one expected entry; idle cycles must show zero data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cpu_valid) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.chk) check(e.nm, {24'h0, cpu_data_out}, {24'h0, e.d});
                end
            end else begin
                check("dout_zero_idle", {24'h0, cpu_data_out}, 32'h0);
            end
        end
    end

    task automatic cpu_op(input bit wr, input bit oe, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp,
                          input int lat, input string nm);
        sb_t e;
        int  got;
        e.chk = oe && !wr;
        e.d   = exp;
        e.nm  = nm;
        sb_q.push_back(e);
        cpu_address = a;
        cpu_wren    = wr;
        cpu_oe      = oe;
        cpu_data_in = d;
        @(posedge clk);
        #1;
        cpu_wren = 1'b0;
        cpu_oe   = 1'b0;
        got      = 0;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            @(negedge clk);
            if (cpu_valid) got = i;
        end
        if (got == 0) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end else begin
            check({nm, "_lat"}, got, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic n64_write(input logic [8:0] a, input logic [31:0] d);
        n64_address = a;
        n64_data_in = d;
        n64_wren    = 1'b1;
        @(posedge clk);
        #1;
        n64_wren = 1'b0;
    endtask

    task automatic n64_read(input logic [8:0] a, input logic [31:0] exp,
                            input string nm);
        n64_address = a;
        @(posedge clk);
        @(negedge clk);
        check(nm, n64_data_out, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input logic [10:0] p);
        cpu_op(1'b1, 1'b0, 4'd0, p[7:0], 8'h00, 1, "ptr_lo_wr");
        cpu_op(1'b1, 1'b0, 4'd1, {5'b0, p[10:8]}, 8'h00, 1, "ptr_hi_wr");
    endtask

    int v0;

    initial begin
        vt[0]  = '{1, 0, 4'd0,  8'h5A, 8'h00, "wr_ptr_lo"};
        vt[1]  = '{1, 0, 4'd1,  8'hFB, 8'h00, "wr_ptr_hi"};
        vt[2]  = '{0, 1, 4'd0,  8'h00, 8'h5A, "rd_ptr_lo"};
        vt[3]  = '{0, 1, 4'd1,  8'h00, 8'h03, "rd_ptr_hi"};
        vt[4]  = '{1, 0, 4'd4,  8'h01, 8'h00, "wr_irq_en"};
        vt[5]  = '{0, 1, 4'd4,  8'h00, 8'h01, "rd_irq_en1"};
        vt[6]  = '{1, 0, 4'd4,  8'h00, 8'h00, "clr_irq_en"};
        vt[7]  = '{0, 1, 4'd4,  8'h00, 8'h00, "rd_irq_en0"};
        vt[8]  = '{0, 1, 4'd3,  8'h00, 8'h00, "rd_status0"};
        vt[9]  = '{0, 1, 4'd5,  8'h00, 8'h00, "rd_reg5"};
        vt[10] = '{1, 0, 4'd7,  8'hFF, 8'h00, "wr_reg7"};
        vt[11] = '{0, 1, 4'd15, 8'h00, 8'h00, "rd_reg15"};
        vt[12] = '{1, 1, 4'd0,  8'h33, 8'h00, "wr_oe_both"};
        vt[13] = '{0, 1, 4'd0,  8'h00, 8'h33, "rd_after_both"};

        reset       = 1'b1;
        n64_address = 9'h0;
        n64_wren    = 1'b0;
        n64_data_in = 32'h0;
        cpu_address = 4'h0;
        cpu_wren    = 1'b0;
        cpu_oe      = 1'b0;
        cpu_data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_n64_dout", n64_data_out, 32'h0);
        check("rst_cpu_dout", {24'h0, cpu_data_out}, 32'h0);
        check("rst_cpu_valid", {31'h0, cpu_valid}, 32'h0);
        check("rst_cmd_irq", {31'h0, cmd_irq}, 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        cpu_op(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1, "rst_ptr_lo");

        for (int i = 0; i < 14; i++) begin
            cpu_op(vt[i].wr, vt[i].oe, vt[i].a, vt[i].d, vt[i].exp, 1, vt[i].nm);
        end

        // ROM protect: prefill word 0x010 from the CPU side.
        set_ptr(11'h040);
        cpu_op(1'b1, 1'b0, 4'd2, 8'h01, 8'h00, 3, "fill0");
        cpu_op(1'b1, 1'b0, 4'd2, 8'h02, 8'h00, 3, "fill1");
        cpu_op(1'b1, 1'b0, 4'd2, 8'h03, 8'h00, 3, "fill2");
        cpu_op(1'b1, 1'b0, 4'd2, 8'h04, 8'h00, 3, "fill3");
        n64_write(9'h010, 32'hDEADBEEF);
        n64_read(9'h010, 32'h01020304, "rom_locked_word");
        set_ptr(11'h040);
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h01, 2, "rom_locked_b0");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h02, 2, "rom_locked_b1");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h03, 2, "rom_locked_b2");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h04, 2, "rom_locked_b3");
        cpu_op(1'b1, 1'b0, 4'd3, 8'h04, 8'h00, 1, "unlock_wr");
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h04, 1, "status_unlock");
        n64_write(9'h010, 32'hDEADBEEF);
        set_ptr(11'h040);
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'hDE, 2, "rom_open_b0");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'hAD, 2, "rom_open_b1");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'hBE, 2, "rom_open_b2");
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'hEF, 2, "rom_open_b3");

        // Byte writes into lanes 2 and 1 of word 0x1F0.
        n64_write(9'h1F0, 32'h12345678);
        set_ptr(11'h7C1);
        cpu_op(1'b1, 1'b0, 4'd2, 8'h11, 8'h00, 3, "bw_11");
        cpu_op(1'b1, 1'b0, 4'd2, 8'h22, 8'h00, 3, "bw_22");
        n64_read(9'h1F0, 32'h12112278, "bw_word");
        cpu_op(1'b0, 1'b1, 4'd0, 8'h00, 8'hC3, 1, "bw_ptr_lo");
        cpu_op(1'b0, 1'b1, 4'd1, 8'h00, 8'h07, 1, "bw_ptr_hi");

        // Pointer wrap on the last byte of the RAM.
        n64_write(9'h1FF, 32'hCAFEF00D);
        set_ptr(11'h7FF);
        cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h0D, 2, "wrap_rd");
        cpu_op(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1, "wrap_ptr_lo");
        cpu_op(1'b0, 1'b1, 4'd1, 8'h00, 8'h00, 1, "wrap_ptr_hi");
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h05, 1, "wrap_status");
        cpu_op(1'b1, 1'b0, 4'd3, 8'h01, 8'h00, 1, "clr_pend");
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h04, 1, "status_clr");

        // Same-word N64 write during RD forces a restart.
        set_ptr(11'h7C0);
        fork
            cpu_op(1'b1, 1'b0, 4'd2, 8'h55, 8'h00, 5, "coll_wr");
            begin
                @(posedge clk);
                #1;
                n64_write(9'h1F0, 32'hAABBCCDD);
            end
        join
        n64_read(9'h1F0, 32'h55BBCCDD, "coll_word");

        // Different-word N64 write during WR only stalls one cycle.
        n64_write(9'h1F1, 32'h00000000);
        set_ptr(11'h7C4);
        fork
            cpu_op(1'b1, 1'b0, 4'd2, 8'h77, 8'h00, 4, "stall_wr");
            begin
                repeat (2) @(posedge clk);
                #1;
                n64_write(9'h1F2, 32'hA5A5A5A5);
            end
        join
        n64_read(9'h1F1, 32'h77000000, "stall_word");
        n64_read(9'h1F2, 32'hA5A5A5A5, "stall_n64_word");

        // Command flag and interrupt latency.
        cpu_op(1'b1, 1'b0, 4'd4, 8'h01, 8'h00, 1, "irq_en_on");
        n64_address = 9'h1FF;
        n64_data_in = 32'h11111111;
        n64_wren    = 1'b1;
        @(negedge clk);
        check("irq_before", {31'h0, cmd_irq}, 32'h0);
        @(posedge clk);
        #1;
        n64_wren = 1'b0;
        @(negedge clk);
        check("irq_pend_cycle", {31'h0, cmd_irq}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("irq_after", {31'h0, cmd_irq}, 32'h1);
        @(posedge clk);
        #1;
        fork
            cpu_op(1'b1, 1'b0, 4'd3, 8'h01, 8'h00, 1, "clr_vs_set");
            n64_write(9'h1FF, 32'h22222222);
        join
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h05, 1, "set_wins");
        cpu_op(1'b1, 1'b0, 4'd3, 8'h01, 8'h00, 1, "clr_pend2");
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h04, 1, "status_clr2");
        @(negedge clk);
        check("irq_cleared", {31'h0, cmd_irq}, 32'h0);
        @(posedge clk);
        #1;

        // A strobe during RD is dropped.
        set_ptr(11'h7C0);
        v0 = n_valid;
        fork
            cpu_op(1'b0, 1'b1, 4'd2, 8'h00, 8'h55, 2, "busy_rd");
            begin
                @(posedge clk);
                #1;
                cpu_address = 4'd0;
                cpu_oe      = 1'b1;
                @(posedge clk);
                #1;
                cpu_oe = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("busy_one_valid", n_valid - v0, 32'd1);
        cpu_op(1'b0, 1'b1, 4'd0, 8'h00, 8'hC1, 1, "busy_ptr_lo");

        // Reset while the RMW sits in WR.
        n64_write(9'h1F2, 32'h01020304);
        set_ptr(11'h7C8);
        v0 = n_valid;
        cpu_address = 4'd2;
        cpu_data_in = 8'h99;
        cpu_wren    = 1'b1;
        @(posedge clk);
        #1;
        cpu_wren = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rwr_n64_dout", n64_data_out, 32'h0);
        check("rwr_cpu_dout", {24'h0, cpu_data_out}, 32'h0);
        check("rwr_cpu_valid", {31'h0, cpu_valid}, 32'h0);
        check("rwr_cmd_irq", {31'h0, cmd_irq}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("rwr_no_valid", n_valid - v0, 32'd0);
        n64_read(9'h1F2, 32'h01020304, "rwr_word");
        cpu_op(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1, "rwr_ptr_lo");
        cpu_op(1'b0, 1'b1, 4'd3, 8'h00, 8'h00, 1, "rwr_status");
        cpu_op(1'b0, 1'b1, 4'd4, 8'h00, 8'h00, 1, "rwr_irq_en");
        n64_write(9'h010, 32'h00000000);
        n64_read(9'h010, 32'hDEADBEEF, "relock_word");

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/pif_ram_arbiter.md
# pif_ram_arbiter

Shared 2 KB PIF memory (512 x 32-bit words) with arbitration between the N64 serial word port and the PIF CPU byte port. The N64-side port connects directly to the serial interface's `pif_interface_*` signals; the CPU side uses the same 4-bit register bus as the rest of the PIF peripherals. Enforces boot-ROM write protection on the N64 side, and flags N64 writes to the PIF command word with an interrupt.

## Interface
- `RAM_BASE_WORD`, 9'h1F0: first N64-writable word; words below it are ROM to the N64.
- `CMD_WORD`, 9'h1FF: word whose N64 write raises `cmd_pending`.
- `clk`  input  1  single clock; N64-side signals arrive already synchronous to it.
- `reset`  input  1  synchronous, active-high.
- `n64_address`  input  9  word address from the serial interface.
- `n64_wren`  input  1  one-cycle write strobe.
- `n64_data_in`  input  32  write data from the serial interface.
- `n64_data_out`  output  32  registered read data.
- `cpu_address`  input  4  register select.
- `cpu_wren`  input  1  write strobe.
- `cpu_oe`  input  1  read strobe.
- `cpu_data_in`  input  8  write data.
- `cpu_data_out`  output  8  read data, valid with `cpu_valid`.
- `cpu_valid`  output  1  one-cycle completion pulse.
- `cmd_irq`  output  1  `cmd_pending & irq_en`, registered.

## Operation
- Storage: 512x32, two read ports (N64, CPU) and one write port. Not reset.
- Byte order is big-endian: byte address b maps to word b[10:2], lane (3-b[1:0])*8.
- CPU register map:
  - 0: ptr[7:0]
  - 1: ptr[10:8] (bits 2:0)
  - 2: data port
  - 3: status. Read gives {5'b0, rom_unlock, busy, cmd_pending}. Write: bit0=1 clears pending, bit2 sets rom_unlock.
  - 4: irq_en (bit0)
  - others: read 0, write ignored.
- N64 write: if `n64_address >= RAM_BASE_WORD` or `rom_unlock`, the word is written in the same cycle; otherwise it is dropped. An accepted write to `CMD_WORD` sets `cmd_pending`.
- N64 read: `n64_data_out` is the word at `n64_address` sampled on the previous edge. A write to the same address shows the new data on the next cycle (write-first).
- CPU state machine:
  - IDLE: a strobe on a register address completes directly. A strobe on address 2 latches ptr and direction, then goes to RD.
  - RD: issue the CPU read of word ptr[10:2].
    - Read access: go to DONE, with the addressed byte selected.
    - Write access: go to WR with the word held.
  - WR: merge `cpu_data_in` (latched at strobe) into the held lane and write.
    - If `n64_wren` is active this cycle (port conflict), stay in WR.
    - If any accepted N64 write hit the same word since RD, go back to RD (no clobber).
    - Otherwise go to DONE.
  - DONE: pulse `cpu_valid`, ptr <= ptr+1 (11-bit, 0x7FF wraps to 0x000), return to IDLE.
- `busy` = state != IDLE. Strobes while busy are ignored and produce no `cpu_valid`.
- A simultaneous strobe on `cpu_wren` and `cpu_oe`: write wins.
- `cmd_pending`: if an N64 set and a CPU clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - outputs: `n64_data_out`=0, `cpu_data_out`=0, `cpu_valid`=0, `cmd_irq`=0
  - internal: ptr=0, `cmd_pending`=0, `irq_en`=0, `rom_unlock`=0, state IDLE.
- Reset mid-RMW aborts the access: no RAM write, no `cpu_valid`.
- Register access: strobe at cycle T, `cpu_valid` and data at T+1.
- Data read: strobe at T, `cpu_valid` at T+2.
- Data write: strobe at T, RAM written at T+2, `cpu_valid` at T+3. Each N64 conflict cycle adds one cycle; a same-word N64 hit adds 2+ cycles (restart).
- `cpu_data_out` is 0 in every cycle without `cpu_valid`.
- `cmd_irq` follows `cmd_pending`/`irq_en` with one cycle of latency.
- N64 read latency is 1 cycle; the serial interface samples data in its decode state, one cycle after the address is presented.

## Test plan
- ROM protect:
  - N64 writes 0xDEADBEEF to word 0x010 with unlock=0; CPU reads bytes 0x040-0x043 -> prior contents.
  - Repeat with unlock=1 -> DE,AD,BE,EF.
- Byte write and word readback: CPU ptr=0x7C1, data writes 0x11, 0x22 -> N64 read of word 0x1F0 shows 0x??1122?? (other lanes unchanged); ptr ends at 0x7C3.
- Wrap: ptr=0x7FF, one data read -> `cpu_valid` at T+2, ptr reads back 0x000.
- Collision: CPU write to byte 0x7C0 while N64 writes 0xAABBCCDD to word 0x1F0 during CPU RD -> RMW restarts; final word 0x55BBCCDD for CPU data 0x55.
- Command flag:
  - N64 write to 0x1FF with irq_en=1 -> `cmd_irq`=1 one cycle after pending.
  - CPU clear in the same cycle as a second 0x1FF write -> pending stays 1.
- Busy drop and reset:
  - A second strobe during RD -> ignored, exactly one `cpu_valid`.
  - `reset` asserted in WR -> RAM word unchanged, all outputs 0.
